// File: rtl/prod_accum_pkg.sv
// rtl/prod_accum_pkg.sv - shared state enum, accumulator width and saturation limit helpers
package prod_accum_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic int acc_width(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    // Returns the two's-complement limit for a w-bit accumulator in the low w bits.
    function automatic logic [63:0] sat_limit(input int w, input logic neg);
        logic [63:0] max_val;
        max_val = (64'd1 << (w - 1)) - 64'd1;
        return neg ? ~max_val : max_val;
    endfunction

endpackage

// File: rtl/prod_accum_if.sv
// rtl/prod_accum_if.sv - product input and result output handshake bundle
interface prod_accum_if
    import prod_accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GUARD = 2
);
    localparam int ACC_W = acc_width(WIDTH, GUARD);

    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   in_prod;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_sum;
    logic                 out_ovf;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

endinterface

// File: rtl/prod_accum_add.sv
// rtl/prod_accum_add.sv - sign-extending adder with overflow detect; PROD_ACCUM_SAT_EN selects saturation
module prod_accum_add
    import prod_accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GUARD = 2
) (
    input  logic [acc_width(WIDTH, GUARD)-1:0] acc,
    input  logic [2*WIDTH-1:0]                 prod,
    output logic [acc_width(WIDTH, GUARD)-1:0] sum,
    output logic                               ovf
);
    localparam int ACC_W = acc_width(WIDTH, GUARD);

    logic [ACC_W:0] wide;

    // One extra bit keeps the true sign so overflow is just a top-two-bit mismatch.
    assign wide = {acc[ACC_W-1], acc} + {{(GUARD + 1){prod[2*WIDTH-1]}}, prod};
    assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

`ifdef PROD_ACCUM_SAT_EN
    localparam logic [63:0] SAT_MAX_W = sat_limit(ACC_W, 1'b0);
    localparam logic [63:0] SAT_MIN_W = sat_limit(ACC_W, 1'b1);
    localparam logic [ACC_W-1:0] SAT_MAX = SAT_MAX_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SAT_MIN = SAT_MIN_W[ACC_W-1:0];

    always_comb begin
        sum = wide[ACC_W-1:0];
        if (ovf) begin
            sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - registered dot-product accumulator of LEN products; PROD_ACCUM_SAT_EN enables saturation
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN   = 4,
    parameter int GUARD = 2
) (
    input logic         clk,
    input logic         rst_n,
    prod_accum_if.slave bus
);
    localparam int ACC_W = acc_width(WIDTH, GUARD);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    state_e           state;
    state_e           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W-1:0] sum_q;
    logic             ovf_q;
    logic             in_hs;
    logic             last_hs;

    prod_accum_add #(
        .WIDTH (WIDTH),
        .GUARD (GUARD)
    ) u_add (
        .acc  (acc),
        .prod (bus.in_prod),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    assign in_hs   = bus.in_valid & bus.in_ready;
    assign last_hs = in_hs && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (last_hs)       state_nxt = HOLD;
            HOLD:    if (bus.out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // in_ready depends only on state (and reset), never on out_ready or in_valid.
    always_comb begin
        bus.in_ready  = rst_n && (state == ACC);
        bus.out_valid = (state == HOLD);
        bus.out_sum   = sum_q;
        bus.out_ovf   = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (in_hs) begin
            if (last_hs) begin
                sum_q <= add_sum;
                ovf_q <= ovf | add_ovf;
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
            end else begin
                acc   <= add_sum;
                cnt   <= cnt + CNT_W'(1);
                ovf   <= ovf | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - scoreboard bench driving GUARD=2 and GUARD=0 instances with shared stimulus
module tb_prod_accum;

    localparam int WIDTH = 8;
    localparam int LEN   = 4;
    localparam int W_A   = 2 * WIDTH + 2;
    localparam int W_B   = 2 * WIDTH;

    typedef struct {
        longint sum_a;
        bit     ovf_a;
        longint sum_b;
        bit     ovf_b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        out_ready;

    int     n_checks = 0;
    int     n_fail   = 0;
    exp_t   sb[$];
    longint m_acc_a, m_acc_b;
    bit     m_ovf_a, m_ovf_b;
    int     m_cnt;

    always #5 clk = ~clk;

    prod_accum_if #(.WIDTH(WIDTH), .GUARD(2)) bus_a ();
    prod_accum_if #(.WIDTH(WIDTH), .GUARD(0)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_prod   = in_prod;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_prod   = in_prod;
    assign bus_b.out_ready = out_ready;

    prod_accum #(.WIDTH(WIDTH), .LEN(LEN), .GUARD(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    prod_accum #(.WIDTH(WIDTH), .LEN(LEN), .GUARD(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input longint p, input int w, inout longint acc, inout bit ovf);
        longint hi, lo, s;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        s  = acc + p;
        if (s > hi || s < lo) begin
            ovf = 1'b1;
`ifdef PROD_ACCUM_SAT_EN
            s = (s > hi) ? hi : lo;
`else
            s = (s > hi) ? s - (longint'(1) << w) : s + (longint'(1) << w);
`endif
        end
        acc = s;
    endtask

    task automatic model_reset();
        m_acc_a = 0; m_acc_b = 0;
        m_ovf_a = 0; m_ovf_b = 0;
        m_cnt   = 0;
    endtask

    task automatic model_add(input longint p);
        exp_t e;
        model_step(p, W_A, m_acc_a, m_ovf_a);
        model_step(p, W_B, m_acc_b, m_ovf_b);
        m_cnt++;
        if (m_cnt == LEN) begin
            e.sum_a = m_acc_a; e.ovf_a = m_ovf_a;
            e.sum_b = m_acc_b; e.ovf_b = m_ovf_b;
            sb.push_back(e);
            model_reset();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input int p, input int gap);
        int n = 0;
        in_valid = 1'b1;
        in_prod  = 16'(p);
        @(negedge clk);
        while (!bus_a.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", bus_a.in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_add(p);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus_a.out_valid && out_ready) begin
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sum_a", longint'($signed(bus_a.out_sum)), e.sum_a);
                    check("ovf_a", bus_a.out_ovf, e.ovf_a);
                    check("valid_b", bus_b.out_valid, 1);
                    check("sum_b", longint'($signed(bus_b.out_sum)), e.sum_b);
                    check("ovf_b", bus_b.out_ovf, e.ovf_b);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stim
        model_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_prod   = 16'd5;
        out_ready = 1'b1;

        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_in_ready", bus_a.in_ready, 0);
            check("rst_out_valid", bus_a.out_valid, 0);
            check("rst_out_sum", bus_a.out_sum, 0);
            check("rst_out_ovf_b", bus_b.out_ovf, 0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus_a.in_ready, 1);
        @(posedge clk);
        #1;

        // Basic group, result one cycle after the last handshake.
        send(15, 0); send(-16256, 0); send(16384, 0); send(100, 0);
        check("lat_out_valid", bus_a.out_valid, 1);
        check("hold_in_ready", bus_a.in_ready, 0);
        check("basic_sum", longint'($signed(bus_a.out_sum)), 243);

        // Backpressure: result held, offered product not taken.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(1000, 0); send(-2000, 0); send(3000, 0); send(-4000, 0);
        in_valid = 1'b1;
        in_prod  = 16'd777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", bus_a.out_valid, 1);
            check("bp_in_ready", bus_a.in_ready, 0);
            check("bp_sum_stable", longint'($signed(bus_a.out_sum)), -2000);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", bus_a.out_valid, 0);
        check("bp_release_ready", bus_a.in_ready, 1);

        // Gaps between products.
        send(15, 2); send(-16256, 2); send(16384, 2); send(100, 2);

        // Positive and negative overflow in the narrow instance.
        send(16384, 0); send(16384, 0); send(0, 0); send(0, 0);
        send(-16256, 0); send(-16256, 0); send(-16256, 0); send(-16256, 0);

        // Reset mid-group discards the partial sum.
        send(7, 0); send(9, 0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);

        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < LEN; k++) begin
                send(int'($urandom_range(32640, 0)) - 16256, int'($urandom_range(2, 0)));
            end
        end

        repeat (6) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
